// File: rtl/alu_seq_ctrl.sv
// Button-stepped ALU sequencer: each debounced press captures A, then B, then
// computes and shows the result, then clears the display.
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | waiting for the press that captures A
// GOT_A | A held, waiting for the press that captures B
// GOT_B | A and B held, next press computes the result
// SHOW  | result valid for display, next press clears it
module alu_seq_ctrl #(
   parameter int DB_LEN = 1000000
) (
   input  logic       clkt,
   input  logic       rst,
   input  logic       button,
   input  logic [3:0] asw,
   input  logic [3:0] bsw,
   input  logic [1:0] in,
   output logic       aload,
   output logic       bload,
   output logic [3:0] a_val,
   output logic [3:0] b_val,
   output logic [1:0] op_q,
   output logic [7:0] result,
   output logic       res_valid,
   output logic [1:0] state
);

   localparam int CW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
   localparam logic [CW-1:0] DB_MAX = CW'(DB_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GOT_A = 2'd1,
      GOT_B = 2'd2,
      SHOW  = 2'd3
   } state_t;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic          db_lvl_q, db_lvl_d;
   logic          db_prev_q, db_prev_d;
   logic          step;

   state_t        state_q, state_d;
   logic [3:0]    a_val_q, a_val_d;
   logic [3:0]    b_val_q, b_val_d;
   logic [1:0]    op_sel_q, op_sel_d;
   logic [7:0]    result_q, result_d;
   logic          res_valid_q, res_valid_d;
   logic          aload_q, aload_d;
   logic          bload_q, bload_d;
   logic [7:0]    alu_res;
   logic [7:0]    a_ext, b_ext;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level, so any glitch back to the old level restarts the count.
   always_comb begin
      sync1_d   = button;
      sync2_d   = sync1_q;
      db_cnt_d  = '0;
      db_lvl_d  = db_lvl_q;
      db_prev_d = db_lvl_q;
      if (sync2_q != db_lvl_q) begin
         if (db_cnt_q == DB_MAX) begin
            db_lvl_d = sync2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + CW'(1);
         end
      end
   end

   assign step = db_lvl_q & ~db_prev_q;

   assign a_ext = {4'b0000, a_val_q};
   assign b_ext = {4'b0000, b_val_q};

   always_comb begin
      alu_res = 8'h00;
      case (in)
         2'd0:    alu_res = a_ext + b_ext;
         2'd1:    alu_res = a_ext - b_ext;
         2'd2:    alu_res = a_ext * b_ext;
         default: alu_res = a_ext & b_ext;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      a_val_d     = a_val_q;
      b_val_d     = b_val_q;
      op_sel_d    = op_sel_q;
      result_d    = result_q;
      res_valid_d = res_valid_q;
      aload_d     = 1'b0;
      bload_d     = 1'b0;
      if (step) begin
         case (state_q)
            IDLE: begin
               a_val_d = asw;
               aload_d = 1'b1;
               state_d = GOT_A;
            end
            GOT_A: begin
               b_val_d = bsw;
               bload_d = 1'b1;
               state_d = GOT_B;
            end
            GOT_B: begin
               op_sel_d    = in;
               result_d    = alu_res;
               res_valid_d = 1'b1;
               state_d     = SHOW;
            end
            default: begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clkt) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         db_cnt_q    <= '0;
         db_lvl_q    <= 1'b0;
         db_prev_q   <= 1'b0;
         state_q     <= IDLE;
         a_val_q     <= 4'h0;
         b_val_q     <= 4'h0;
         op_sel_q    <= 2'd0;
         result_q    <= 8'h00;
         res_valid_q <= 1'b0;
         aload_q     <= 1'b0;
         bload_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         db_cnt_q    <= db_cnt_d;
         db_lvl_q    <= db_lvl_d;
         db_prev_q   <= db_prev_d;
         state_q     <= state_d;
         a_val_q     <= a_val_d;
         b_val_q     <= b_val_d;
         op_sel_q    <= op_sel_d;
         result_q    <= result_d;
         res_valid_q <= res_valid_d;
         aload_q     <= aload_d;
         bload_q     <= bload_d;
      end
   end

   assign aload     = aload_q;
   assign bload     = bload_q;
   assign a_val     = a_val_q;
   assign b_val     = b_val_q;
   assign op_q      = op_sel_q;
   assign result    = result_q;
   assign res_valid = res_valid_q;
   assign state     = state_q;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DB_LEN, default 1000000, meaning stable-cycle count needed to accept a button level change (10 ms at 100 MHz); benches SHALL override it to 4.
REQ-002 The block SHALL have port clkt, input, 1, the single clock; all flops update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port button, input, 1, raw asynchronous pushbutton, the step request.
REQ-005 The block SHALL have port asw, input, 4, operand A switches.
REQ-006 The block SHALL have port bsw, input, 4, operand B switches.
REQ-007 The block SHALL have port in, input, 2, ALU operation select: 0 add, 1 sub, 2 mul, 3 and.
REQ-008 The block SHALL have port aload, output, 1, one-cycle pulse when A is captured.
REQ-009 The block SHALL have port bload, output, 1, one-cycle pulse when B is captured.
REQ-010 The block SHALL have port a_val, output, 4, registered operand A.
REQ-011 The block SHALL have port b_val, output, 4, registered operand B.
REQ-012 The block SHALL have port op_q, output, 2, registered operation.
REQ-013 The block SHALL have port result, output, 8, registered ALU result for the 7-segment path.
REQ-014 The block SHALL have port res_valid, output, 1, high while result is valid for display.
REQ-015 The block SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-016 button SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-017 Debounce: a counter SHALL increment each cycle sync2 differs from the debounced level and clear when equal; on the cycle it equals DB_LEN-1 while still differing, the debounced level SHALL take sync2 and the counter SHALL clear.
REQ-018 An internal step SHALL be high for exactly one cycle on each rising edge of the debounced level; falling edges SHALL produce no step.
REQ-019 With button held stable high, the FSM SHALL act on clock edge DB_LEN+3, counting the first edge that samples button=1 as edge 1.
REQ-020 A level held for fewer than DB_LEN consecutive synchronized cycles SHALL produce no step.
REQ-021 FSM states SHALL be IDLE=0, GOT_A=1, GOT_B=2, SHOW=3; without step the state SHALL hold.
REQ-022 IDLE plus step: a_val<=asw, aload=1 for that one cycle, next state GOT_A.
REQ-023 GOT_A plus step: b_val<=bsw, bload=1 for that one cycle, next state GOT_B.
REQ-024 GOT_B plus step: op_q<=in, result<=ALU(a_val,b_val,in), res_valid<=1, next state SHOW; result SHALL be visible one cycle after the step cycle.
REQ-025 SHOW plus step: res_valid<=0, next state IDLE; a_val, b_val, op_q and result SHALL hold their values.
REQ-026 asw, bsw and in SHALL be sampled only at the capturing edge; changes at other times SHALL have no effect.
REQ-027 ALU arithmetic SHALL zero-extend operands to 8 bits: add A+B; sub (A-B) mod 256; mul A*B (max 225, no overflow); and {4'b0, A&B}.
REQ-028 aload and bload SHALL never be high in the same cycle and SHALL be low in every cycle other than their capture cycle.

Reset
REQ-029 rst high at a clock edge SHALL set state=IDLE and set a_val, b_val, op_q, result, res_valid, aload, bload, sync1, sync2, the debounce counter and the debounced level to 0.
REQ-030 rst SHALL take priority over a simultaneous step.
REQ-031 If button is held through reset release, a step SHALL occur DB_LEN+3 edges after the first non-reset edge.

Verification (DB_LEN=4)
REQ-032 Reset test: rst high for 2 cycles -> state=0, result=0, res_valid=0, aload=bload=0.
REQ-033 Add sequence: asw=4, bsw=2, in=0, three clean presses -> aload pulse with a_val=4, then bload pulse with b_val=2, then result=8'h06, res_valid=1, state=3.
REQ-034 Sub wrap: A=3, B=6, in=1 -> result=8'hFD; mul: A=15, B=15, in=2 -> result=8'hE1; and: A=8, B=9, in=3 -> result=8'h08.
REQ-035 Bounce: button high 2 cycles, low 1, high 2, low -> no step, state unchanged, no aload pulse.
REQ-036 Reset mid-operation in GOT_B with button held -> state=0 and res_valid=0 at the next edge; after rst drops, state=1 at edge DB_LEN+3 with one aload pulse.
REQ-037 Switch change: asw changed while in GOT_A -> a_val unchanged; a fourth press from SHOW -> state=0, res_valid=0, result held.
